reservation_station: RTL

- Holds issued ALU operations until both source operands are available, then dispatches one ready op per cycle to the execute unit.
- Captures operands from the common data bus (CDB), tagged by ROB index.
- Sits between the issue stage and exec; its dispatch fields map directly onto exec's func, rs1_data, rs2_data, rob_ind and rd inputs.

---
 rtl/reservation_station_if.sv | 61 ++++++
 rtl/reservation_station.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/reservation_station_if.sv
// Issue, CDB and dispatch signal bundle for the reservation station.
// The master side drives issue/CDB/flush and accepts dispatched ops; the
// slave side is the reservation station itself.
interface reservation_station_if #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int TW    = 3,
  parameter int RW    = 4,
  parameter int FW    = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  // issue side
  logic          iss_valid;
  logic          iss_ready;
  logic [FW-1:0] iss_func;
  logic [RW-1:0] iss_rd;
  logic [TW-1:0] iss_rob;
  logic [DW-1:0] iss_vj;
  logic [TW-1:0] iss_qj;
  logic          iss_qj_pend;
  logic [DW-1:0] iss_vk;
  logic [TW-1:0] iss_qk;
  logic          iss_qk_pend;
  // common data bus
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  // dispatch side
  logic          disp_valid;
  logic          disp_ready;
  logic [FW-1:0] disp_func;
  logic [DW-1:0] disp_rs1;
  logic [DW-1:0] disp_rs2;
  logic [TW-1:0] disp_rob;
  logic [RW-1:0] disp_rd;
  logic [CW-1:0] count;

  modport master (
    output flush,
    output iss_valid, iss_func, iss_rd, iss_rob,
    output iss_vj, iss_qj, iss_qj_pend, iss_vk, iss_qk, iss_qk_pend,
    output cdb_valid, cdb_tag, cdb_data,
    output disp_ready,
    input  iss_ready,
    input  disp_valid, disp_func, disp_rs1, disp_rs2, disp_rob, disp_rd,
    input  count
  );

  modport slave (
    input  flush,
    input  iss_valid, iss_func, iss_rd, iss_rob,
    input  iss_vj, iss_qj, iss_qj_pend, iss_vk, iss_qk, iss_qk_pend,
    input  cdb_valid, cdb_tag, cdb_data,
    input  disp_ready,
    output iss_ready,
    output disp_valid, disp_func, disp_rs1, disp_rs2, disp_rob, disp_rd,
    output count
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds issued ALU ops until both operands have been
// captured (at issue or from the CDB), then presents the lowest-index ready
// op to exec. One issue and one dispatch per cycle at most.
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int TW    = 3,
  parameter int RW    = 4,
  parameter int FW    = 4
) (
  input logic                  clk1,
  input logic                  rst,
  reservation_station_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  // Per-entry state gathered into vectors/arrays for the selectors
  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] pj_vec;
  logic [DEPTH-1:0] pk_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [FW-1:0]    func_arr [DEPTH];
  logic [RW-1:0]    rd_arr   [DEPTH];
  logic [TW-1:0]    rob_arr  [DEPTH];
  logic [DW-1:0]    vj_arr   [DEPTH];
  logic [DW-1:0]    vk_arr   [DEPTH];

  logic [CW-1:0]    count_reg;

  logic             iss_ready_int;
  logic             issue_fire;
  logic             disp_fire;
  logic             disp_any;
  logic [IW-1:0]    disp_idx;
  logic             free_any;
  logic [IW-1:0]    free_idx;
  logic             byp_j;
  logic             byp_k;

  assign ready_vec     = busy_vec & ~pj_vec & ~pk_vec;
  // Free-slot availability comes only from the registered count, so a slot
  // released by this cycle's dispatch cannot be refilled until next cycle.
  assign iss_ready_int = (count_reg < CW'(DEPTH));
  assign issue_fire    = bus.iss_valid & iss_ready_int;
  assign disp_fire     = disp_any & bus.disp_ready;

  // A pending operand whose producer is broadcasting right now is taken
  // straight from the CDB instead of waiting another cycle.
  assign byp_j = bus.iss_qj_pend & bus.cdb_valid & (bus.iss_qj == bus.cdb_tag);
  assign byp_k = bus.iss_qk_pend & bus.cdb_valid & (bus.iss_qk == bus.cdb_tag);

  // Lowest-index ready entry for dispatch
  always_comb begin
    disp_any = 1'b0;
    disp_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        disp_any = 1'b1;
        disp_idx = IW'(i);
      end
    end
  end

  // Lowest-index free entry for issue
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic          busy_reg;
      logic          pj_reg;
      logic          pk_reg;
      logic [FW-1:0] func_reg;
      logic [RW-1:0] rd_reg;
      logic [TW-1:0] rob_reg;
      logic [DW-1:0] vj_reg;
      logic [TW-1:0] qj_reg;
      logic [DW-1:0] vk_reg;
      logic [TW-1:0] qk_reg;
      logic          issue_here;
      logic          disp_here;
      logic          cap_j;
      logic          cap_k;

      assign issue_here = issue_fire & free_any & (free_idx == IW'(gi));
      assign disp_here  = disp_fire & (disp_idx == IW'(gi));
      assign cap_j      = busy_reg & pj_reg & bus.cdb_valid & (qj_reg == bus.cdb_tag);
      assign cap_k      = busy_reg & pk_reg & bus.cdb_valid & (qk_reg == bus.cdb_tag);

      // Entry update: reset/flush clear, otherwise issue write, dispatch
      // release and CDB operand capture
      always_ff @(posedge clk1) begin
        if (rst || bus.flush) begin
          busy_reg <= 1'b0;
          pj_reg   <= 1'b0;
          pk_reg   <= 1'b0;
        end else if (issue_here) begin
          // Issue only targets a free entry, so no dispatch/capture overlap
          busy_reg <= 1'b1;
          func_reg <= bus.iss_func;
          rd_reg   <= bus.iss_rd;
          rob_reg  <= bus.iss_rob;
          qj_reg   <= bus.iss_qj;
          qk_reg   <= bus.iss_qk;
          vj_reg   <= byp_j ? bus.cdb_data : bus.iss_vj;
          vk_reg   <= byp_k ? bus.cdb_data : bus.iss_vk;
          pj_reg   <= bus.iss_qj_pend & ~byp_j;
          pk_reg   <= bus.iss_qk_pend & ~byp_k;
        end else begin
          if (disp_here) begin
            busy_reg <= 1'b0;
          end
          if (cap_j) begin
            vj_reg <= bus.cdb_data;
            pj_reg <= 1'b0;
          end
          if (cap_k) begin
            vk_reg <= bus.cdb_data;
            pk_reg <= 1'b0;
          end
        end
      end

      assign busy_vec[gi] = busy_reg;
      assign pj_vec[gi]   = pj_reg;
      assign pk_vec[gi]   = pk_reg;
      assign func_arr[gi] = func_reg;
      assign rd_arr[gi]   = rd_reg;
      assign rob_arr[gi]  = rob_reg;
      assign vj_arr[gi]   = vj_reg;
      assign vk_arr[gi]   = vk_reg;
    end
  endgenerate

  // Occupancy: +1 on accepted issue, -1 on accepted dispatch
  always_ff @(posedge clk1) begin
    if (rst || bus.flush) begin
      count_reg <= '0;
    end else if (issue_fire && !disp_fire) begin
      count_reg <= count_reg + CW'(1);
    end else if (!issue_fire && disp_fire) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  // Dispatch fields read zero when nothing is presented
  assign bus.iss_ready  = iss_ready_int;
  assign bus.count      = count_reg;
  assign bus.disp_valid = disp_any;
  assign bus.disp_func  = disp_any ? func_arr[disp_idx] : '0;
  assign bus.disp_rs1   = disp_any ? vj_arr[disp_idx]   : '0;
  assign bus.disp_rs2   = disp_any ? vk_arr[disp_idx]   : '0;
  assign bus.disp_rob   = disp_any ? rob_arr[disp_idx]  : '0;
  assign bus.disp_rd    = disp_any ? rd_arr[disp_idx]   : '0;

endmodule
